// File: rtl/y86_pkg.sv
// Shared Y86-64 constants: instruction codes, special register IDs, data width default.
// Also provides the decoded-ID bundle and the register-ID validity helper.
package y86_pkg;

  localparam int REG_W_DEF = 64;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RRSP  = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

  typedef struct packed {
    logic [3:0] src_a;
    logic [3:0] src_b;
    logic [3:0] dst_e;
    logic [3:0] dst_m;
  } dec_ids_t;

  // An ID names a real register only if it is not "none" and fits the file.
  function automatic logic id_ok(logic [3:0] id, int nreg);
    return (id != RNONE) && (int'(id) < nreg);
  endfunction

endpackage

// File: rtl/decode_writeback_if.sv
// Decode/writeback bus: instruction fields and writeback data in, IDs and read data out.
interface decode_writeback_if import y86_pkg::*; #(parameter int REG_W = REG_W_DEF);
  logic [3:0]       icode;
  logic [3:0]       rA;
  logic [3:0]       rB;
  logic [REG_W-1:0] valE;
  logic [REG_W-1:0] valM;
  logic             cnd;
  logic             wb_en;
  logic [REG_W-1:0] valA;
  logic [REG_W-1:0] valB;
  logic [3:0]       srcA;
  logic [3:0]       srcB;
  logic [3:0]       dstE;
  logic [3:0]       dstM;

  modport master (output icode, rA, rB, valE, valM, cnd, wb_en,
                  input  valA, valB, srcA, srcB, dstE, dstM);
  modport slave  (input  icode, rA, rB, valE, valM, cnd, wb_en,
                  output valA, valB, srcA, srcB, dstE, dstM);
endinterface

// File: rtl/regfile_2r2w.sv
// Register file: 2 async read ports, 2 write ports, port 1 wins on same-address writes.
// Async active-low clear; out-of-range addresses read 0 and are never written.
module regfile_2r2w #(
  parameter int W  = 64,
  parameter int N  = 15,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] ra0,
  input  logic [AW-1:0] ra1,
  output logic [W-1:0]  rd0,
  output logic [W-1:0]  rd1,
  input  logic          we0,
  input  logic [AW-1:0] wa0,
  input  logic [W-1:0]  wd0,
  input  logic          we1,
  input  logic [AW-1:0] wa1,
  input  logic [W-1:0]  wd1
);

  logic [W-1:0] regs [N];

  for (genvar g = 0; g < N; g++) begin : g_reg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          regs[g] <= '0;
      else if (we1 && wa1 == AW'(g))       regs[g] <= wd1;
      else if (we0 && wa0 == AW'(g))       regs[g] <= wd0;
    end
  end

  always_comb begin
    rd0 = '0;
    rd1 = '0;
    for (int i = 0; i < N; i++) begin
      if (ra0 == AW'(i)) rd0 = regs[i];
      if (ra1 == AW'(i)) rd1 = regs[i];
    end
  end

endmodule

// File: rtl/decode_writeback.sv
// Y86-64 decode + writeback: register ID decode, register file reads and writes.
// Define DECODE_WB_BYPASS_EN to forward same-cycle writeback data onto valA/valB.
module decode_writeback import y86_pkg::*; #(
  parameter int REG_W = REG_W_DEF,
  parameter int NREG  = 15
) (
  input logic               clk,
  input logic               rst_n,
  decode_writeback_if.slave bus
);

  dec_ids_t         ids;
  logic             we_e, we_m;
  logic [REG_W-1:0] rd_a, rd_b;

  always_comb begin
    ids = '{src_a: RNONE, src_b: RNONE, dst_e: RNONE, dst_m: RNONE};
    case (bus.icode)
      IRRMOVQ: begin ids.src_a = bus.rA; ids.dst_e = bus.cnd ? bus.rB : RNONE; end
      IIRMOVQ: ids.dst_e = bus.rB;
      IRMMOVQ: begin ids.src_a = bus.rA; ids.src_b = bus.rB; end
      IMRMOVQ: begin ids.src_b = bus.rB; ids.dst_m = bus.rA; end
      IOPQ:    begin ids.src_a = bus.rA; ids.src_b = bus.rB; ids.dst_e = bus.rB; end
      ICALL:   begin ids.src_b = RRSP; ids.dst_e = RRSP; end
      IRET:    begin ids.src_a = RRSP; ids.src_b = RRSP; ids.dst_e = RRSP; end
      IPUSHQ:  begin ids.src_a = bus.rA; ids.src_b = RRSP; ids.dst_e = RRSP; end
      IPOPQ:   begin ids.src_a = RRSP; ids.src_b = RRSP; ids.dst_e = RRSP; ids.dst_m = bus.rA; end
      default: ;
    endcase
  end

  assign bus.srcA = ids.src_a;
  assign bus.srcB = ids.src_b;
  assign bus.dstE = ids.dst_e;
  assign bus.dstM = ids.dst_m;

  assign we_e = bus.wb_en && id_ok(ids.dst_e, NREG);
  assign we_m = bus.wb_en && id_ok(ids.dst_m, NREG);

  // valM rides port 1 so it overrides valE when both target the same register.
  regfile_2r2w #(.W(REG_W), .N(NREG), .AW(4)) u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .ra0   (ids.src_a),
    .ra1   (ids.src_b),
    .rd0   (rd_a),
    .rd1   (rd_b),
    .we0   (we_e),
    .wa0   (ids.dst_e),
    .wd0   (bus.valE),
    .we1   (we_m),
    .wa1   (ids.dst_m),
    .wd1   (bus.valM)
  );

`ifdef DECODE_WB_BYPASS_EN
  always_comb begin
    bus.valA = rd_a;
    if (we_m && ids.src_a == ids.dst_m)      bus.valA = bus.valM;
    else if (we_e && ids.src_a == ids.dst_e) bus.valA = bus.valE;
    bus.valB = rd_b;
    if (we_m && ids.src_b == ids.dst_m)      bus.valB = bus.valM;
    else if (we_e && ids.src_b == ids.dst_e) bus.valB = bus.valE;
  end
`else
  assign bus.valA = rd_a;
  assign bus.valB = rd_b;
`endif

endmodule

// File: doc/decode_writeback.md
DECODE_WRITEBACK -- requirements
Module: decode_writeback

Interface
REQ-001 The block SHALL have parameter REG_W, default 64, meaning register data width in bits.
REQ-002 The block SHALL have parameter NREG, default 15, meaning the number of architectural registers (IDs 0x0-0xE; ID 0xF means "none").
REQ-003 Port clk, input, 1: the single clock; all state updates occur on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port icode, input, 4: instruction code of the current instruction.
REQ-006 Port rA, input, 4: first register specifier.
REQ-007 Port rB, input, 4: second register specifier.
REQ-008 Port valE, input, REG_W: execute-stage result, written to dstE.
REQ-009 Port valM, input, REG_W: memory-stage result, written to dstM.
REQ-010 Port cnd, input, 1: condition flag from execute; gates the cmovXX write.
REQ-011 Port wb_en, input, 1: writeback enable; when low, no register is written.
REQ-012 Port valA, output, REG_W: read data for srcA.
REQ-013 Port valB, output, REG_W: read data for srcB.
REQ-014 Ports srcA, srcB, dstE, dstM, output, 4 each: decoded register IDs (0xF means none).

Function
REQ-015 srcA SHALL be rA for icode 2, 4, 6, A; 4 (%rsp) for icode 9 and B; 0xF otherwise.
REQ-016 srcB SHALL be rB for icode 4, 5, 6; 4 for icode 8, 9, A, B; 0xF otherwise.
REQ-017 dstE SHALL be rB for icode 3 and 6; rB for icode 2 only when cnd=1, else 0xF; 4 for icode 8, 9, A, B; 0xF otherwise.
REQ-018 dstM SHALL be rA for icode 5 and B; 0xF otherwise.
REQ-019 valA and valB SHALL be combinational reads of the register file; a source of 0xF SHALL read 0.
REQ-020 On a rising clk edge with wb_en=1, the block SHALL write valE to reg[dstE] and valM to reg[dstM], skipping any destination of 0xF.
REQ-021 When dstE==dstM (for example popq %rsp), valM SHALL win, and the register SHALL hold valM after the edge.
REQ-022 Writes SHALL take effect in a single cycle; reads in the following cycle SHALL see the new value.
REQ-023 Destination IDs of 0xF or greater than or equal to NREG SHALL cause no write and no error.
REQ-024 Unknown icode values SHALL decode all four IDs to 0xF.

Reset
REQ-025 While rst_n=0, all registers SHALL be cleared to 0 immediately, without waiting for a clock edge; valA and valB SHALL therefore read 0.
REQ-026 A write edge that coincides with an active rst_n SHALL be discarded.
REQ-027 When rst_n deasserts mid-stream, the first following edge SHALL write normally.

Configuration
REQ-028 With macro DECODE_WB_BYPASS_EN defined, valA and valB SHALL return the pending valM (priority) or valE whenever the source matches a valid dstM or dstE and wb_en=1, giving same-cycle write-to-read forwarding.
REQ-029 Without DECODE_WB_BYPASS_EN, reads SHALL return the stored register contents only.

Structure
REQ-030 The icode constants (IHALT through IPOPQ), the RRSP=4 and RNONE=0xF constants, and the REG_W default SHALL live in the shared package y86_pkg.
REQ-031 The register storage SHALL be the sub-module regfile_2r2w, with 2 asynchronous read ports, 2 write ports, and port-1 write priority.

Verification
REQ-032 irmovq (icode 3, rB=2, valE=0x1234, wb_en=1) then a read of srcA=2 via rrmovq -> valA=0x1234 in the next cycle.
REQ-033 cmovle with cnd=0, rB=3, valE=0xAA -> dstE=0xF and reg3 unchanged; repeating with cnd=1 -> reg3=0xAA.
REQ-034 popq %rsp (rA=4, valE=0x108, valM=0x55) -> reg4=0x55 after the edge.
REQ-035 pushq (icode A, rA=1) with reg4=0x100 -> srcA=1, srcB=4, dstE=4, and valB=0x100.
REQ-036 Load reg5=0x77, then pulse rst_n low between clock edges -> valA reads 0 immediately, and reg5=0 after rst_n deasserts.
REQ-037 With DECODE_WB_BYPASS_EN defined, a same-cycle write of reg6=0x9 with a read of reg6 -> valA=0x9 before the edge; without the macro -> valA=old value.
